// File: rtl/flash_pkg.sv
// Shared definitions for the flash generator: channel mode encodings and
// default parameter values.
package flash_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PULSE = 2'd3
    } mode_e;

    localparam int unsigned DEF_CLK_DIV = 50000;
    localparam int unsigned DEF_NCH     = 4;
    localparam int unsigned DEF_PW      = 10;
    localparam int unsigned DEF_CHW     = 2;

endpackage

// File: rtl/flash_chan.sv
// One flash channel: holds its configuration, phase counter and registered
// level / wrap / pulse-done outputs.
//   clk, reset      clock, async active-high reset
//   we              configuration write aimed at this channel
//   restart         zero the phase and re-evaluate the level for phase 0
//   tick            shared base tick (phase advances only here)
//   mode_in, period_in, on_in   configuration payload for a write
//   ch_out          flash level
//   ch_tick         one-clk pulse on a BLINK phase wrap
//   ch_done         one-clk pulse when a PULSE completes
module flash_chan
    import flash_pkg::*;
#(
    parameter int unsigned PW = DEF_PW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          restart,
    input  logic          tick,
    input  logic [1:0]    mode_in,
    input  logic [PW-1:0] period_in,
    input  logic [PW-1:0] on_in,
    output logic          ch_out,
    output logic          ch_tick,
    output logic          ch_done
);

    mode_e          mode_q,   mode_d;
    logic [PW-1:0]  period_q, period_d;
    logic [PW-1:0]  on_q,     on_d;
    logic [PW-1:0]  phase_q,  phase_d;
    logic           out_q,    out_d;
    logic           tick_q,   tick_d;
    logic           done_q,   done_d;

    logic           wrap;
    logic [PW-1:0]  phase_inc;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q   <= MODE_OFF;
            period_q <= '0;
            on_q     <= '0;
            phase_q  <= '0;
            out_q    <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            on_q     <= on_d;
            phase_q  <= phase_d;
            out_q    <= out_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    // Next state: write beats restart beats tick; in PULSE mode the phase
    // counter doubles as the elapsed on-time.
    always_comb begin
        mode_d    = mode_q;
        period_d  = period_q;
        on_d      = on_q;
        phase_d   = phase_q;
        out_d     = out_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;
        wrap      = (phase_q == period_q);
        phase_inc = wrap ? '0 : phase_q + PW'(1);

        if (we) begin
            mode_d   = mode_e'(mode_in);
            period_d = period_in;
            on_d     = on_in;
            phase_d  = '0;
            case (mode_e'(mode_in))
                MODE_OFF:   out_d = 1'b0;
                MODE_ON:    out_d = 1'b1;
                MODE_BLINK: out_d = (on_in != '0);
                MODE_PULSE: begin
                    // Zero-length pulse completes immediately.
                    if (on_in == '0) begin
                        mode_d = MODE_OFF;
                        out_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        out_d  = 1'b1;
                    end
                end
            endcase
        end else if (restart) begin
            phase_d = '0;
            case (mode_q)
                MODE_OFF:   out_d = 1'b0;
                MODE_ON:    out_d = 1'b1;
                MODE_BLINK: out_d = (on_q != '0);
                MODE_PULSE: out_d = 1'b1;
            endcase
        end else if (tick) begin
            case (mode_q)
                MODE_OFF: begin
                    phase_d = '0;
                    out_d   = 1'b0;
                end
                MODE_ON: begin
                    phase_d = '0;
                    out_d   = 1'b1;
                end
                MODE_BLINK: begin
                    phase_d = phase_inc;
                    tick_d  = wrap;
                    out_d   = (phase_inc < on_q);
                end
                MODE_PULSE: begin
                    if (phase_q + PW'(1) == on_q) begin
                        mode_d  = MODE_OFF;
                        phase_d = '0;
                        out_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        phase_d = phase_q + PW'(1);
                        out_d   = 1'b1;
                    end
                end
            endcase
        end
    end

    assign ch_out  = out_q;
    assign ch_tick = tick_q;
    assign ch_done = done_q;

endmodule

// File: rtl/flash_gen.sv
// Multi-channel flash generator: a shared prescaler produces base_tick and
// drives NCH independent flash channels configured through a write port.
//   clk, reset          clock, async active-high reset
//   enable              prescaler advance enable
//   sync_restart        zero prescaler and all channel phases
//   cfg_we/cfg_ch       configuration write strobe and target channel
//   cfg_mode/period/on  configuration payload
//   base_tick           high in the cycle the prescaler wraps
//   ch_out/ch_tick/ch_done  per-channel level, BLINK wrap, PULSE done
module flash_gen
    import flash_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV,
    parameter int unsigned NCH     = DEF_NCH,
    parameter int unsigned PW      = DEF_PW,
    parameter int unsigned CHW     = DEF_CHW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           sync_restart,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [1:0]     cfg_mode,
    input  logic [PW-1:0]  cfg_period,
    input  logic [PW-1:0]  cfg_on,
    output logic           base_tick,
    output logic [NCH-1:0] ch_out,
    output logic [NCH-1:0] ch_tick,
    output logic [NCH-1:0] ch_done
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] CNT_TOP = DW'(CLK_DIV - 1);

    logic [DW-1:0]  cnt_q, cnt_d;
    logic           at_top;
    logic [NCH-1:0] ch_we;

    // Prescaler register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Prescaler next count; restart wins over a coincident wrap
    always_comb begin
        cnt_d = cnt_q;
        if (sync_restart)   cnt_d = '0;
        else if (enable)    cnt_d = at_top ? '0 : cnt_q + DW'(1);
    end

    assign at_top    = (cnt_q == CNT_TOP);
    assign base_tick = enable && at_top;

    // Per-channel write decode; out-of-range channels match nothing
    always_comb begin
        ch_we = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            ch_we[i] = cfg_we && (32'(cfg_ch) == i);
        end
    end

    for (genvar g = 0; g < int'(NCH); g++) begin : g_chan
        flash_chan #(.PW(PW)) u_chan (
            .clk       (clk),
            .reset     (reset),
            .we        (ch_we[g]),
            .restart   (sync_restart),
            .tick      (base_tick),
            .mode_in   (cfg_mode),
            .period_in (cfg_period),
            .on_in     (cfg_on),
            .ch_out    (ch_out[g]),
            .ch_tick   (ch_tick[g]),
            .ch_done   (ch_done[g])
        );
    end

endmodule

// File: tb/tb_flash_gen.sv
// Scoreboard bench for flash_gen (CLK_DIV=4, NCH=3, PW=4, CHW=2).
module tb_flash_gen;

    localparam int DIV = 4;
    localparam int N   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       sync_restart = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [1:0] cfg_mode = '0;
    logic [3:0] cfg_period = '0;
    logic [3:0] cfg_on = '0;
    logic       base_tick;
    logic [2:0] ch_out, ch_tick, ch_done;

    flash_gen #(.CLK_DIV(4), .NCH(3), .PW(4), .CHW(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sync_restart (sync_restart),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_mode     (cfg_mode),
        .cfg_period   (cfg_period),
        .cfg_on       (cfg_on),
        .base_tick    (base_tick),
        .ch_out       (ch_out),
        .ch_tick      (ch_tick),
        .ch_done      (ch_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       bt;
        logic [2:0] out;
        logic [2:0] tick;
        logic [2:0] done;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference model: per channel, base ticks elapsed since the last zeroing.
    int m_cnt;
    int m_mode[N];
    int m_per[N];
    int m_on[N];
    int m_t[N];
    bit m_out[N];
    bit m_tick[N];
    bit m_done[N];

    function automatic bit level(input int c);
        case (m_mode[c])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (m_t[c] % (m_per[c] + 1)) < m_on[c];
            default: return m_t[c] < m_on[c];
        endcase
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        for (int c = 0; c < N; c++) begin
            m_mode[c] = 0; m_per[c] = 0; m_on[c] = 0; m_t[c] = 0;
            m_out[c] = 0; m_tick[c] = 0; m_done[c] = 0;
        end
    endtask

    // Drive one cycle of inputs and push the expected outputs for that cycle.
    task automatic step(input bit rst, input bit en, input bit rs, input bit we,
                        input int ch, input int md, input int per, input int on);
        exp_t e;
        bit   bt;
        @(posedge clk);
        #2;
        reset = rst; enable = en; sync_restart = rs; cfg_we = we;
        cfg_ch = 2'(ch); cfg_mode = 2'(md); cfg_period = 4'(per); cfg_on = 4'(on);
        if (rst) model_reset();
        bt = en && !rst && (m_cnt == DIV - 1);
        e.bt = bt;
        for (int c = 0; c < N; c++) begin
            e.out[c]  = m_out[c];
            e.tick[c] = m_tick[c];
            e.done[c] = m_done[c];
        end
        q.push_back(e);
        if (!rst) begin
            if (rs)      m_cnt = 0;
            else if (en) m_cnt = (m_cnt + 1) % DIV;
            for (int c = 0; c < N; c++) begin
                m_tick[c] = 0;
                m_done[c] = 0;
                if (we && ch == c) begin
                    m_mode[c] = md; m_per[c] = per; m_on[c] = on; m_t[c] = 0;
                    if (md == 3 && on == 0) begin
                        m_mode[c] = 0;
                        m_done[c] = 1;
                    end
                    m_out[c] = level(c);
                end else if (rs) begin
                    m_t[c] = 0;
                    m_out[c] = level(c);
                end else if (bt) begin
                    if (m_mode[c] == 2) begin
                        m_t[c]++;
                        m_tick[c] = (m_t[c] % (m_per[c] + 1)) == 0;
                    end else if (m_mode[c] == 3) begin
                        m_t[c]++;
                        if (m_t[c] >= m_on[c]) begin
                            m_mode[c] = 0;
                            m_t[c] = 0;
                            m_done[c] = 1;
                        end
                    end
                    m_out[c] = level(c);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    // Monitor: compare the DUT against the queued expectation every cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("base_tick", {2'b00, base_tick}, {2'b00, e.bt});
                chk("ch_out",  ch_out,  e.out);
                chk("ch_tick", ch_tick, e.tick);
                chk("ch_done", ch_done, e.done);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) step(1, 1, 0, 0, 0, 0, 0, 0);
        idle(13);
        // BLINK examples: regular, on > period, on = 0
        step(0, 1, 0, 1, 0, 2, 4, 2);
        step(0, 1, 0, 1, 1, 2, 3, 7);
        step(0, 1, 0, 1, 2, 2, 4, 0);
        idle(50);
        // PULSE of three base ticks on ch2
        step(0, 1, 0, 1, 2, 3, 0, 3);
        idle(20);
        // Restart in mid-period
        for (int k = 0; k < 8 && m_cnt != 1; k++) idle(1);
        idle(4);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        idle(12);
        // Write to a nonexistent channel
        step(0, 1, 0, 1, 3, 1, 5, 5);
        idle(8);
        // Zero-length PULSE, then PULSE interrupted by restart
        step(0, 1, 0, 1, 1, 3, 0, 0);
        idle(4);
        step(0, 1, 0, 1, 0, 3, 0, 5);
        idle(9);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        idle(24);
        // Enable low holds everything
        repeat (10) step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(6);
        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            step(($urandom % 500) == 0,
                 ($urandom % 10) != 0,
                 ($urandom % 40) == 0,
                 ($urandom % 8) == 0,
                 int'($urandom % 4),
                 int'($urandom % 4),
                 int'($urandom % 16),
                 int'($urandom % 16));
        end
        idle(2);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flash_gen.md
FLASH_GEN -- requirements
Module: flash_gen

Interface
REQ-001 Parameter CLK_DIV, default 50000; clk cycles per base tick, legal range 2 or more.
REQ-002 Parameter NCH, default 4; number of independent flash channels, legal range 1..16.
REQ-003 Parameter PW, default 10; width of the period and on-time fields.
REQ-004 Parameter CHW, default 2; width of cfg_ch.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 clk  in  1  clock.
REQ-007 enable  in  1  prescaler advance enable; when low, all counters hold.
REQ-008 sync_restart  in  1  one-cycle pulse that zeroes the prescaler and all channel phases.
REQ-009 cfg_we  in  1  configuration write strobe.
REQ-010 cfg_ch  in  CHW  target channel for the write.
REQ-011 cfg_mode  in  2  mode encoding: 0 OFF, 1 ON, 2 BLINK, 3 PULSE.
REQ-012 cfg_period  in  PW  last phase value; period length is cfg_period+1 base ticks.
REQ-013 cfg_on  in  PW  on-time in base ticks.
REQ-014 base_tick  out  1  one-clk pulse per prescaler wrap.
REQ-015 ch_out  out  NCH  registered flash level per channel.
REQ-016 ch_tick  out  NCH  one-clk pulse on each channel phase wrap, BLINK mode only.
REQ-017 ch_done  out  NCH  one-clk pulse when a PULSE completes.

Function
REQ-018 Prescaler: counts 0..CLK_DIV-1 while enable=1; base_tick=1 exactly in cycles where enable=1 and count=CLK_DIV-1; the count wraps to 0 in the same cycle.
REQ-019 Channel phase: advances only in base_tick cycles; in BLINK mode, phase=period wraps to 0 and asserts ch_tick for that cycle.
REQ-020 BLINK level rule: ch_out = (next phase < on); ch_out updates on the same edge as the phase (no extra latency).
REQ-021 on > period in BLINK mode: ch_out constant 1. on=0: ch_out constant 0.
REQ-022 period=0 in BLINK mode: phase stays 0; ch_tick fires every base_tick.
REQ-023 OFF mode: ch_out=0 and phase held at 0. ON mode: ch_out=1 and phase held at 0.
REQ-024 PULSE mode: ch_out=1 from the write until on base ticks have elapsed. On that tick, ch_out=0, mode reverts to OFF, and ch_done pulses for one clk.
REQ-025 PULSE mode with on=0: the channel reverts to OFF and asserts ch_done on the cycle after the write, with ch_out staying 0.
REQ-026 cfg_we: writes mode, period and on for channel cfg_ch and zeroes its phase. ch_out reflects the new configuration from the next clk.
REQ-027 cfg_ch >= NCH: the write is ignored and no state changes.
REQ-028 sync_restart: prescaler=0, all phases=0, and ch_out is re-evaluated for phase 0; configuration is kept; an in-progress PULSE restarts its on-time.
REQ-029 sync_restart and cfg_we in the same cycle: both apply, and the written channel starts at phase 0 with the new configuration.
REQ-030 sync_restart, or cfg_we to a channel, coinciding with base_tick: the affected counters are zeroed, with no advance on that tick.

Reset
REQ-031 On reset, the following are 0: prescaler, all phases, all modes (OFF), period, on, base_tick, ch_out, ch_tick and ch_done.
REQ-032 The first base_tick after reset release occurs CLK_DIV enabled cycles later.

Structure
REQ-033 Shared package flash_pkg holds the mode encodings MODE_OFF, MODE_ON, MODE_BLINK and MODE_PULSE, plus the default parameter values.
REQ-034 One sub-module, flash_chan, is instantiated NCH times; it holds config, phase, ch_out, ch_tick and ch_done for one channel.
REQ-035 The prescaler is in the top level and is shared by all channels.

Verification (CLK_DIV=4, NCH=3, PW=4, CHW=2)
REQ-036 Reset then enable=1 -> all outputs 0; base_tick at clks 4, 8, 12, and so on.
REQ-037 ch0 BLINK with period=4, on=2 -> ch_out0 repeats 1,1,0,0,0 per base tick; ch_tick0 every 20 clks.
REQ-038 ch1 BLINK with period=3, on=7 -> ch_out1 stuck at 1; ch2 BLINK with on=0 -> ch_out2 stuck at 0.
REQ-039 ch2 PULSE with on=3 -> ch_out2 high for 3 base ticks, then a single ch_done2 pulse, then OFF mode with ch_out2 at 0.
REQ-040 sync_restart at mid-period (phase 2) -> all phases 0, and the next base_tick arrives 4 clks later.
REQ-041 cfg_we with cfg_ch=3 -> no change on any output or state.
